// File: rtl/mem_access_stage.sv
// Memory-stage access controller: issues cache requests, stalls upstream until dhit, steers MEM/WB latch.
// Optional load-linked/store-conditional reservation enabled by defining LLSC_EN.
module mem_access_stage #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              valid_mem,
   input  logic              MemRead_mem,
   input  logic              MemWrite_mem,
   input  logic              ll_mem,
   input  logic              sc_mem,
   input  logic              halt_mem,
   input  logic [WORD_W-1:0] addr_mem,
   input  logic [WORD_W-1:0] storedata_mem,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   input  logic              snoop_inv,
   input  logic [WORD_W-1:0] snoop_addr,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic [WORD_W-1:0] dmemload_mem,
   output logic              sc_ok_mem,
   output logic              stall_mem,
   output logic              en_mw,
   output logic              flush_mw,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halted_s, op_s, req_s, halt_req_s, sc_fail_s, done_s;
   logic             ren_s, wen_s, stall_s, en_s, flush_s;

   assign halted_s   = (state_q == ST_HALT);
   // Gating with RST keeps requests low for the whole reset pulse, not just after it.
   assign op_s       = ~RST & valid_mem & (MemRead_mem | MemWrite_mem) & ~halted_s;
   assign halt_req_s = ~RST & valid_mem & halt_mem & (state_q == ST_IDLE);
   assign req_s      = op_s & ~sc_fail_s;
   assign done_s     = (ren_s | wen_s) & dhit;

`ifdef LLSC_EN
   logic              link_valid_q, link_valid_d;
   logic [WORD_W-1:0] link_addr_q, link_addr_d;
   logic              link_match_s;

   assign link_match_s = link_valid_q & (addr_mem == link_addr_q);
   assign sc_fail_s    = op_s & MemWrite_mem & sc_mem & ~link_match_s;
   assign sc_ok_mem    = wen_s & sc_mem & dhit;

   // Reservation update; later assignments take precedence so an LL completion beats a same-cycle snoop.
   always_comb begin
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      if (snoop_inv && (snoop_addr == link_addr_q)) begin
         link_valid_d = 1'b0;
      end else begin
         link_valid_d = link_valid_q;
      end
      if (sc_fail_s || (done_s && wen_s && (sc_mem || (addr_mem == link_addr_q)))) begin
         link_valid_d = 1'b0;
      end else begin
         link_valid_d = link_valid_d;
      end
      if (done_s && ren_s && ll_mem) begin
         link_valid_d = 1'b1;
         link_addr_d  = addr_mem;
      end else begin
         link_addr_d  = link_addr_q;
      end
   end

   // Reservation registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else begin
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
      end
   end
`else
   logic unused_s;

   assign sc_fail_s = 1'b0;
   assign sc_ok_mem = ~RST & sc_mem & valid_mem;
   assign unused_s  = &{1'b0, ll_mem, snoop_inv, snoop_addr};
`endif

   // Access FSM: request, stall and MEM/WB latch control.
   always_comb begin
      state_d = state_q;
      ren_s   = 1'b0;
      wen_s   = 1'b0;
      stall_s = 1'b0;
      en_s    = 1'b0;
      flush_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (halt_req_s) begin
               en_s    = 1'b1;
               state_d = ST_HALT;
            end else if (req_s) begin
               ren_s = MemRead_mem;
               wen_s = MemWrite_mem;
               if (dhit) begin
                  en_s = 1'b1;
               end else begin
                  stall_s = 1'b1;
                  flush_s = 1'b1;
                  state_d = ST_WAIT;
               end
            end else begin
               en_s = 1'b1;
            end
         end
         ST_WAIT: begin
            if (op_s) begin
               ren_s = MemRead_mem;
               wen_s = MemWrite_mem;
               if (dhit) begin
                  en_s    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  stall_s = 1'b1;
                  flush_s = 1'b1;
               end
            end else begin
               en_s    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_HALT: begin
            stall_s = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Saturating stall counter; halted cycles are not memory stalls.
   always_comb begin
      if (stall_s && !halted_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State and counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dmemREN      = ren_s;
   assign dmemWEN      = wen_s;
   assign dmemaddr     = addr_mem;
   assign dmemstore    = storedata_mem;
   assign dmemload_mem = (dhit && ren_s) ? dmemload : '0;
   assign stall_mem    = stall_s;
   assign en_mw        = en_s;
   assign flush_mw     = flush_s;
   assign halted       = halted_s;
   assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven self-checking bench for mem_access_stage with a per-cycle expectation queue.
module tb_mem_access_stage;

   typedef struct {
      logic        valid, rd, wr, ll, sc, halt, hit, sinv;
      logic [31:0] addr, sdata, dload, saddr;
      logic        e_ren, e_wen, e_stall, e_en, e_flush, e_scok;
      logic [31:0] e_load;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        valid_mem, MemRead_mem, MemWrite_mem, ll_mem, sc_mem, halt_mem, dhit, snoop_inv;
   logic [31:0] addr_mem, storedata_mem, dmemload, snoop_addr;
   logic        dmemREN, dmemWEN, sc_ok_mem, stall_mem, en_mw, flush_mw, halted;
   logic [31:0] dmemaddr, dmemstore, dmemload_mem, stall_cnt;

   int   total = 0;
   int   bad   = 0;
   vec_t exp_q[$];

`ifdef LLSC_EN
   localparam bit LLSC = 1'b1;
`else
   localparam bit LLSC = 1'b0;
`endif

   mem_access_stage #(.WORD_W(32), .CNT_W(32)) dut (
      .CLK(CLK), .RST(RST), .valid_mem(valid_mem), .MemRead_mem(MemRead_mem),
      .MemWrite_mem(MemWrite_mem), .ll_mem(ll_mem), .sc_mem(sc_mem), .halt_mem(halt_mem),
      .addr_mem(addr_mem), .storedata_mem(storedata_mem), .dhit(dhit), .dmemload(dmemload),
      .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload_mem(dmemload_mem),
      .sc_ok_mem(sc_ok_mem), .stall_mem(stall_mem), .en_mw(en_mw), .flush_mw(flush_mw),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, rd, wr, ll, sc, hl, hit,
                               input logic [31:0] addr, sdata, dload,
                               input logic sinv, input logic [31:0] saddr,
                               input logic ren, wen, stl, en, fl, scok,
                               input logic [31:0] ld);
      vec_t r;
      r.valid = v;  r.rd = rd; r.wr = wr; r.ll = ll; r.sc = sc; r.halt = hl; r.hit = hit;
      r.addr = addr; r.sdata = sdata; r.dload = dload; r.sinv = sinv; r.saddr = saddr;
      r.e_ren = ren; r.e_wen = wen; r.e_stall = stl; r.e_en = en; r.e_flush = fl;
      r.e_scok = scok; r.e_load = ld;
      return r;
   endfunction

   // Drive one cycle at posedge+1, check at the falling edge, return at the next posedge+1.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      valid_mem = v.valid; MemRead_mem = v.rd; MemWrite_mem = v.wr; ll_mem = v.ll;
      sc_mem = v.sc; halt_mem = v.halt; dhit = v.hit; addr_mem = v.addr;
      storedata_mem = v.sdata; dmemload = v.dload; snoop_inv = v.sinv; snoop_addr = v.saddr;
      exp_q.push_back(v);
      #4;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_ctrl"}, {58'd0, dmemREN, dmemWEN, stall_mem, en_mw, flush_mw, sc_ok_mem},
             {58'd0, e.e_ren, e.e_wen, e.e_stall, e.e_en, e.e_flush, e.e_scok});
         chk({tag, "_load"}, {32'd0, dmemload_mem}, {32'd0, e.e_load});
         chk({tag, "_pass"}, {dmemaddr, dmemstore}, {e.addr, e.sdata});
         chk({tag, "_excl"}, {63'd0, en_mw & flush_mw}, 64'd0);
      end
      @(posedge CLK);
      #1;
   endtask

   function automatic vec_t idle();
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
   endfunction

   task automatic do_reset();
      RST = 1'b1;
      valid_mem = 1'b0; MemRead_mem = 1'b0; MemWrite_mem = 1'b0; ll_mem = 1'b0; sc_mem = 1'b0;
      halt_mem = 1'b0; dhit = 1'b0; addr_mem = 32'h0; storedata_mem = 32'h0; dmemload = 32'h0;
      snoop_inv = 1'b0; snoop_addr = 32'h0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   vec_t tbl[$];

   initial begin
      do_reset();
      chk("rst_cnt", {32'd0, stall_cnt}, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);

      // Reset during WAIT: load 0x100 missing for 3 cycles, then RST mid-access.
      for (int i = 0; i < 3; i++)
         apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0), "rwait");
      chk("rwait_cnt", {32'd0, stall_cnt}, 64'd3);
      #2 RST = 1'b1;
      #1;
      chk("rwait_req", {62'd0, dmemREN, dmemWEN}, 64'd0);
      chk("rwait_stall", {62'd0, stall_mem, flush_mw}, 64'd0);
      chk("rwait_cnt0", {32'd0, stall_cnt}, 64'd0);
      do_reset();
      apply(idle(), "post_rst");

      // Main table: zero-wait load, invalid request, 4-cycle store miss, load miss, SC, stray dhit.
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 32'h0,
                       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0,
                       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h12345678, 32'h0, 1'b0, 32'h0,
                          1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h12345678, 32'h0, 1'b0, 32'h0,
                       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));
      chk("store_miss_cnt", {32'd0, stall_cnt}, 64'd4);

      apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0000AAAA, 1'b0, 32'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0), "ldmiss");
      apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h0BADF00D, 1'b0, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0BADF00D), "ldhit");
      // Without a reservation an SC fails under LLSC_EN, and is a plain store otherwise.
      apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h77, 32'h0, 1'b0, 32'h0,
               1'b0, !LLSC, 1'b0, 1'b1, 1'b0, !LLSC, 32'h0), "sc_plain");
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0), "stray_hit");
      chk("cnt_after_tbl", {32'd0, stall_cnt}, 64'd5);

      // Halt after a store: one en_mw carrying halt, then frozen with no requests.
      apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h5, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0), "pre_halt");
      apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0), "halt");
      for (int i = 0; i < 12; i++) begin
         chk("halted", {63'd0, halted}, 64'd1);
         apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0), "halted_hold");
      end
      chk("halt_cnt", {32'd0, stall_cnt}, 64'd5);

`ifdef LLSC_EN
      do_reset();
      begin
         vec_t ll80, sc_ok, sc_bad;
         ll80   = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h0, 32'h55, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55);
         sc_ok  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h9, 32'h0, 1'b0, 32'h0,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
         sc_bad = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h9, 32'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         apply(ll80, "ll1");
         apply(sc_ok, "sc1");
         apply(sc_bad, "sc2");
         apply(ll80, "ll2");
         apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0), "snoop80");
         apply(sc_bad, "sc_snooped");
         apply(ll80, "ll3");
         apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h84,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0), "snoop84");
         apply(sc_ok, "sc_other_snoop");
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage access controller between the EX/MEM pipeline latch and the MEM/WB latch. It issues load/store requests to the data cache and holds the request until `dhit`. It stalls upstream stages while an access is outstanding and drives `en_mw`/`flush_mw` so the MEM/WB latch captures exactly one copy of each instruction. It also latches halt, tracks a load-linked reservation, and counts memory stall cycles.

## Interface
Parameters:
- `WORD_W`, 32, data and address width.
- `CNT_W`, 32, width of the stall-cycle counter.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `valid_mem` in 1: EX/MEM latch holds a real instruction.
- `MemRead_mem`, `MemWrite_mem` in 1: load / store request.
- `ll_mem`, `sc_mem` in 1: load-linked / store-conditional qualifiers; valid only with read / write.
- `halt_mem` in 1: halt instruction present.
- `addr_mem` in WORD_W: effective address.
- `storedata_mem` in WORD_W: store data.
- `dhit` in 1: cache completed the current request this cycle.
- `dmemload` in WORD_W: cache read data, valid with `dhit`.
- `snoop_inv` in 1, `snoop_addr` in WORD_W: coherence invalidate of a word address.
- `dmemREN`, `dmemWEN` out 1: cache read / write request.
- `dmemaddr`, `dmemstore` out WORD_W: equal to `addr_mem` and `storedata_mem` at all times.
- `dmemload_mem` out WORD_W: load result to the MEM/WB latch.
- `sc_ok_mem` out 1: store-conditional success flag (1 = stored).
- `stall_mem` out 1: freeze PC and the IF/ID, ID/EX and EX/MEM latches.
- `en_mw`, `flush_mw` out 1: MEM/WB latch enable / bubble insert. `en_mw` has priority in the latch.
- `halted` out 1: core has retired halt.
- `stall_cnt` out CNT_W: memory stall cycles since reset, saturating.

## Operation
- `op` = `valid_mem & (MemRead_mem | MemWrite_mem) & !halted`.
- States:
  - IDLE
    - No `op`: `en_mw` = 1, no request, `stall_mem` = 0.
    - With `op`: drive `dmemREN` = `MemRead_mem` and `dmemWEN` = `MemWrite_mem` combinationally in the same cycle.
    - If `dhit`: `en_mw` = 1, stay IDLE (zero-wait access).
    - Else: `stall_mem` = 1, `en_mw` = 0, `flush_mw` = 1, and go to WAIT.
  - WAIT
    - Request held constant; upstream is frozen, so the inputs are stable.
    - While `!dhit`: `stall_mem` = 1, `flush_mw` = 1.
    - On `dhit`: `en_mw` = 1, `stall_mem` = 0, return to IDLE.
  - HALTED
    - Entered from IDLE when `valid_mem & halt_mem`; `en_mw` = 1 that cycle so halt reaches WB.
    - Afterwards: no requests, `stall_mem` = 1, `en_mw` = 0, `flush_mw` = 0, so WB retains `halt_wb`.
    - `halted` = 1. Exit only by reset.
- `dmemload_mem` = `dmemload` while `dhit & dmemREN`, else 0.
- `stall_cnt` increments in every cycle with `stall_mem` = 1 and state ≠ HALTED; it holds at all-ones.
- Reservation (`link_valid`, `link_addr`):
  - Set on completion of LL.
  - Cleared on completion of any SC.
  - Cleared on completion of a store to `link_addr`.
  - Cleared on `snoop_inv` with `snoop_addr == link_addr`.
- Simultaneous snoop and LL completion on the same address: the LL set wins.

## Timing
- Latency: a cache hit asserted in the request cycle gives 0 stall cycles. Otherwise the stall lasts N cycles, where the access completes on the (N+1)th cycle.
- Exactly one `en_mw` pulse per memory instruction. Never `en_mw` and `flush_mw` high together.
- Request outputs drop in the cycle after `dhit` unless a new `op` is present.
- Reset values (asserted asynchronously, mid-access included):
  - State IDLE.
  - `dmemREN` = `dmemWEN` = 0.
  - `stall_mem` = 0, `flush_mw` = 0.
  - `halted` = 0.
  - `link_valid` = 0, `link_addr` = 0.
  - `stall_cnt` = 0.
  - `sc_ok_mem` = 0.
  - `dmemload_mem` = 0.
- An outstanding access is abandoned at reset; the cache is reset by the same signal.
- `valid_mem = 0` with `MemRead_mem` or `MemWrite_mem` set: no request.

## Configuration
- `LLSC_EN` defined:
  - LL behaves as a load and sets the reservation.
  - SC with `link_valid & addr_mem == link_addr` issues the write. It completes on `dhit` with `sc_ok_mem` = 1.
  - A failing SC issues no request, completes in one cycle with `en_mw` = 1 and `sc_ok_mem` = 0, and clears the reservation.
- `LLSC_EN` undefined:
  - No reservation logic; `ll_mem` and `sc_mem` are ignored.
  - SC behaves as a plain store.
  - `sc_ok_mem` = 1 whenever `sc_mem & valid_mem`, else 0.
  - `snoop_*` inputs are unused.

## Test plan
- **Reset during WAIT:** load to 0x100 with `dhit` low 3 cycles, then `RST` pulse. Expect `dmemREN` = 0 immediately, `stall_mem` = 0, `stall_cnt` = 0.
- **Zero-wait load:** load 0x40 with `dhit` = 1 in the same cycle and `dmemload` = 0xDEADBEEF. Expect `stall_mem` never high, one `en_mw` pulse, `dmemload_mem` = 0xDEADBEEF.
- **Store miss:** store to 0x200 with `dhit` after 4 cycles. Expect `stall_mem` and `flush_mw` high for 4 cycles, then a single `en_mw`, and `stall_cnt` = 4.
- **Halt:** halt after a store. Expect one `en_mw` carrying halt, then `stall_mem` = 1, `en_mw` = `flush_mw` = 0 for 10+ cycles, `halted` = 1, no requests.
- **LL/SC success (`LLSC_EN`):** LL 0x80, then SC 0x80. Expect `dmemWEN` asserted and `sc_ok_mem` = 1; a second SC to 0x80 yields no request and `sc_ok_mem` = 0.
- **Reservation break (`LLSC_EN`):** LL 0x80, then `snoop_inv` with `snoop_addr` = 0x80, then SC 0x80. Expect no request and `sc_ok_mem` = 0. Repeat with `snoop_addr` = 0x84: expect SC succeeds.
